sort4_seq: RTL and testbench
============================

Name: sort4_seq

Overview:
- Sequential sorter for four W-bit unsigned values, built around one shared magnitude comparator (the equal/greater/less datapath) that is time-multiplexed across all element pairs.
- Control is bubble sort with early exit when a pass makes no swap.
- Used as the next lab step that turns the combinational comparator into a sequenced datapath with a start/done handshake.

Parameters:
- W, 4, bit width of each element (unsigned).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to sort; sampled only in IDLE
- in0  input  W  element 0
- in1  input  W  element 1
- in2  input  W  element 2
- in3  input  W  element 3
- out0  output  W  sorted result, smallest
- out1  output  W  sorted result, second smallest
- out2  output  W  sorted result, third smallest
- out3  output  W  sorted result, largest
- swap_cnt  output  3  total swaps performed in the last sort (0..6)
- busy  output  1  high while a sort is in progress
- done  output  1  one-cycle pulse when out*/swap_cnt update

Behaviour:
- Single clock; asynchronous active-high reset. While rst is high:
  - state=IDLE;
  - internal regs R0..R3, pass p, index i, pass_swapped flag and swap counter all clear to 0;
  - out0..out3=0, swap_cnt=0, busy=0, done=0.
- Reset mid-sort aborts immediately. No partial result reaches out*.
- States are IDLE, CMP and FIN. busy = (state != IDLE), registered.
- IDLE:
  - If start=1 at a clock edge: R0..R3 <= in0..in3; p<=0; i<=0; pass_swapped<=0; swap counter<=0; go to CMP.
  - in* are sampled only at this edge.
- CMP, one compare per cycle:
  - Compare R[i] against R[i+1] with unsigned magnitude compare.
  - If R[i] > R[i+1], swap them at this edge, set pass_swapped and increment the swap counter.
  - Equal values are never swapped, so the sort is stable.
  - If i < 2-p: i<=i+1.
  - If i = 2-p (end of pass): if p=2, or no swap occurred anywhere in this pass (including this compare), go to FIN. Otherwise p<=p+1, i<=0, pass_swapped<=0.
- FIN:
  - At the edge: out0..out3 <= R0..R3 and swap_cnt <= swap counter; done<=1 for exactly one cycle; go to IDLE.
- done is high in the cycle after the FIN edge, with busy already low.
- start=1 during that done cycle is accepted as a new request.
- start is ignored while busy=1; no queuing and no effect on the current sort.
- out*/swap_cnt hold their value between done pulses.
- Latency, counting the start-sampling edge as edge 0:
  - compares occur on edges 1..N, N = 3, 5 or 6;
  - the FIN edge is N+1, so done is visible after edge N+1;
  - range is 4 cycles (already sorted) to 7 cycles.
- Width rules:
  - swap counter is 3 bits and never exceeds 6;
  - p and i are 2 bits;
  - all compares are unsigned W-bit, with no wrap.

Test Plan:
- After reset, start=1 for one cycle with in=(1,2,3,4) -> 3 compares, done pulse after edge 4, out=(1,2,3,4), swap_cnt=0.
- in=(4,3,2,1) -> done after edge 7, out=(1,2,3,4), swap_cnt=6; busy high for edges 1..7 and low during done.
- in=(3,1,2,0) -> done after edge 7, out=(0,1,2,3), swap_cnt=5.
- in=(2,1,3,4) -> early exit after pass 1, 5 compares, done after edge 6, out=(1,2,3,4), swap_cnt=1.
- Duplicates and extremes:
  - (5,5,5,5) -> done after edge 4, swap_cnt=0;
  - (15,0,15,0) -> done after edge 7, out=(0,0,15,15), swap_cnt=3.
- Robustness, starting from a first sort of in=(4,3,2,1):
  - start re-asserted with new in while busy -> ignored, result of the first sort only;
  - rst asserted asynchronously mid-CMP -> all outputs 0 at once, busy=0, no done pulse;
  - a fresh start after rst releases sorts correctly.

Source files
------------

// File: rtl/sort4_seq.sv
// Sequential four-element bubble sorter with early exit on a swap-free pass.
// One shared magnitude comparator is time-multiplexed across adjacent pairs.
module sort4_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [2:0]   swap_cnt,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StCmp, StFin} state_e;

  state_e       state_q;
  logic [W-1:0] r_q [4];
  logic [W-1:0] out_q [4];
  logic [1:0]   p_q;
  logic [1:0]   i_q;
  logic         swapped_q;
  logic [2:0]   cnt_q;
  logic [2:0]   swap_cnt_q;
  logic         busy_q;
  logic         done_q;

  logic [1:0]   i_nxt;
  logic [W-1:0] cmp_a;
  logic [W-1:0] cmp_b;
  logic         cmp_gt;
  logic         pass_end;

  // Shared comparator: only "greater" matters, equal pairs stay put (stable sort).
  always_comb begin
    i_nxt    = i_q + 2'd1;
    cmp_a    = r_q[i_q];
    cmp_b    = r_q[i_nxt];
    cmp_gt   = (cmp_a > cmp_b);
    pass_end = (i_q == (2'd2 - p_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      for (int k = 0; k < 4; k++) begin
        r_q[k]   <= '0;
        out_q[k] <= '0;
      end
      p_q        <= 2'd0;
      i_q        <= 2'd0;
      swapped_q  <= 1'b0;
      cnt_q      <= 3'd0;
      swap_cnt_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            r_q[0]    <= in0;
            r_q[1]    <= in1;
            r_q[2]    <= in2;
            r_q[3]    <= in3;
            p_q       <= 2'd0;
            i_q       <= 2'd0;
            swapped_q <= 1'b0;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b1;
            state_q   <= StCmp;
          end
        end
        StCmp: begin
          if (cmp_gt) begin
            r_q[i_q]   <= cmp_b;
            r_q[i_nxt] <= cmp_a;
            swapped_q  <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end
          if (!pass_end) begin
            i_q <= i_nxt;
          end else if ((p_q == 2'd2) || !(swapped_q || cmp_gt)) begin
            state_q <= StFin;
          end else begin
            // Later assignment overrides the set above: new pass starts clean.
            p_q       <= p_q + 2'd1;
            i_q       <= 2'd0;
            swapped_q <= 1'b0;
          end
        end
        StFin: begin
          for (int k = 0; k < 4; k++) begin
            out_q[k] <= r_q[k];
          end
          swap_cnt_q <= cnt_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out0     = out_q[0];
  assign out1     = out_q[1];
  assign out2     = out_q[2];
  assign out3     = out_q[3];
  assign swap_cnt = swap_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sort4_seq.sv
// Scoreboard bench for sort4_seq: the driver queues expected results, a monitor
// checks them whenever done pulses.
module tb_sort4_seq;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in0, in1, in2, in3;
  logic [W-1:0] out0, out1, out2, out3;
  logic [2:0]   swap_cnt;
  logic         busy;
  logic         done;

  sort4_seq #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .swap_cnt (swap_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [W-1:0] o3;
    logic [2:0]   cnt;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out0", 32'(out0), 32'(e.o0));
        chk("out1", 32'(out1), 32'(e.o1));
        chk("out2", 32'(out2), 32'(e.o2));
        chk("out3", 32'(out3), 32'(e.o3));
        chk("swap_cnt", 32'(swap_cnt), 32'(e.cnt));
        chk("latency", cyc, e.due);
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Start a sort; with push set, queue the expected result due lat edges later.
  task automatic issue(input logic [W-1:0] a, b, c, d,
                       input logic [W-1:0] e0, e1, e2, e3,
                       input logic [2:0] ecnt, input int unsigned lat, input bit push);
    @(negedge clk);
    in0 = a; in1 = b; in2 = c; in3 = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back('{e0, e1, e2, e3, ecnt, cyc + lat});
  endtask

  // busy must stay high for lat cycles; then wait (bounded) for the monitor.
  task automatic wait_done(input int unsigned lat);
    int n;
    for (int k = 0; k < int'(lat); k++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
    end
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic sort(input logic [W-1:0] a, b, c, d,
                      input logic [W-1:0] e0, e1, e2, e3,
                      input logic [2:0] ecnt, input int unsigned lat);
    issue(a, b, c, d, e0, e1, e2, e3, ecnt, lat, 1'b1);
    wait_done(lat);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out0"}, 32'(out0), 32'd0);
    chk({tag, "_out1"}, 32'(out1), 32'd0);
    chk({tag, "_out2"}, 32'(out2), 32'd0);
    chk({tag, "_out3"}, 32'(out3), 32'd0);
    chk({tag, "_cnt"}, 32'(swap_cnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    sort(4'd1, 4'd2, 4'd3, 4'd4,   4'd1, 4'd2, 4'd3, 4'd4,    3'd0, 4);
    sort(4'd4, 4'd3, 4'd2, 4'd1,   4'd1, 4'd2, 4'd3, 4'd4,    3'd6, 7);
    sort(4'd3, 4'd1, 4'd2, 4'd0,   4'd0, 4'd1, 4'd2, 4'd3,    3'd5, 7);
    sort(4'd2, 4'd1, 4'd3, 4'd4,   4'd1, 4'd2, 4'd3, 4'd4,    3'd1, 6);
    sort(4'd5, 4'd5, 4'd5, 4'd5,   4'd5, 4'd5, 4'd5, 4'd5,    3'd0, 4);
    sort(4'd15, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15,  3'd3, 7);

    // start while busy must be ignored entirely
    issue(4'd4, 4'd3, 4'd2, 4'd1,  4'd1, 4'd2, 4'd3, 4'd4,    3'd6, 7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    in0 = 4'd9; in1 = 4'd8; in2 = 4'd7; in3 = 4'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0);
    repeat (10) @(negedge clk);

    // asynchronous reset mid-CMP clears everything and yields no done
    issue(4'd4, 4'd3, 4'd2, 4'd1,  4'd0, 4'd0, 4'd0, 4'd0,    3'd0, 7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_after_reset_busy", 32'(busy), 32'd0);

    sort(4'd3, 4'd1, 4'd2, 4'd0,   4'd0, 4'd1, 4'd2, 4'd3,    3'd5, 7);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
